// File: rtl/simd_issue_sequencer_pkg.sv
// Shared types for the SIMD issue sequencer: lane opcodes, FSM states, in-flight tag.
package simd_pkg;

  localparam int unsigned ARITH = 0;
  localparam int unsigned CALC  = 1;
  localparam int unsigned COMP  = 2;
  localparam int unsigned CAST  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Travels alongside an issued element until its result is captured.
  typedef struct packed {
    logic last;
  } tag_t;

endpackage

// File: rtl/simd_result_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop together keep the count.
module simd_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign rd_en   = pop_i && (count_q != '0);
  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign wr_en   = push_i && ((count_q != (AW+1)'(DEPTH)) || rd_en);
  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/simd_issue_sequencer.sv
// Sequences one decoded vector instruction into per-cycle compute-lane controls and
// collects lane results into a credit-protected FIFO so the lane never stalls.
module simd_issue_sequencer
  import simd_pkg::*;
#(
  parameter int OPCODE_BITS   = 4,
  parameter int FUNCTION_BITS = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ELEM_BITS     = 16,
  parameter int CU_LATENCY    = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OPCODE_BITS-1:0]   instr_opcode,
  input  logic [FUNCTION_BITS-1:0] instr_fn,
  input  logic [ELEM_BITS-1:0]     instr_num_elems,
  input  logic                     instr_reduction_flag,
  input  logic                     instr_reduction_dim,
  input  logic [DATA_WIDTH-1:0]    instr_identity,
  input  logic                     opnd_valid,
  output logic                     opnd_ready,
  input  logic [DATA_WIDTH-1:0]    opnd_data0,
  input  logic [DATA_WIDTH-1:0]    opnd_data1,
  output logic [OPCODE_BITS-1:0]   cu_opcode,
  output logic [FUNCTION_BITS-1:0] cu_fn,
  output logic [DATA_WIDTH-1:0]    cu_data_in0,
  output logic [DATA_WIDTH-1:0]    cu_data_in1,
  output logic                     cu_acc_reset,
  output logic                     cu_reduction_flag,
  output logic                     cu_reduction_dim,
  input  logic [DATA_WIDTH-1:0]    cu_data_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH-1:0]    res_data,
  output logic                     res_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH + CU_LATENCY + 1) + 2;

  state_e                  state_q, state_d;
  logic                    red_q, dim_q, first_q;
  logic [DATA_WIDTH-1:0]   ident_q;
  logic [ELEM_BITS-1:0]    rem_q;
  logic [CU_LATENCY:0]     vld_pipe_q;
  tag_t [CU_LATENCY:0]     tag_pipe_q;
  tag_t                    new_tag;

  logic [CW-1:0]           fifo_cnt;
  logic                    fifo_empty;
  logic [DATA_WIDTH:0]     fifo_rdata;
  logic [PW-1:0]           inflight, used;
  logic                    credit_ok, last_elem, instr_hs, opnd_hs;
  logic                    push_tag, pop_vld, pop_last;

  logic [DATA_WIDTH-1:0]   in0_d, in1_d;
  logic                    acc_d, flag_d;

  assign last_elem     = (rem_q == ELEM_BITS'(1));
  assign instr_hs      = instr_valid && instr_ready;
  assign opnd_hs       = opnd_valid && opnd_ready;
  assign push_tag      = opnd_hs && (!red_q || last_elem);
  assign new_tag.last  = last_elem;
  assign pop_vld       = vld_pipe_q[CU_LATENCY];
  assign pop_last      = pop_vld && tag_pipe_q[CU_LATENCY].last;

  // Credits: every issued-but-uncaptured tag plus every FIFO entry holds one slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= CU_LATENCY; i++) inflight = inflight + PW'(vld_pipe_q[i]);
  end
  assign used      = PW'(fifo_cnt) + inflight;
  assign credit_ok = (used < PW'(FIFO_DEPTH));

  // Next state and handshake readiness.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    opnd_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && (instr_num_elems != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        // Intermediate reduction elements produce no result, so they need no credit.
        opnd_ready = (red_q && !last_elem) || credit_ok;
        if (opnd_valid && opnd_ready && last_elem) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_last) begin
          instr_ready = 1'b1;
          state_d     = (instr_valid && (instr_num_elems != '0)) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane inputs for the next cycle; bubbles feed identity so a running reduction holds.
  always_comb begin
    acc_d  = 1'b0;
    flag_d = red_q && !first_q;
    in0_d  = red_q ? ident_q : '0;
    in1_d  = red_q ? ident_q : '0;
    if (opnd_hs) begin
      if (!red_q) begin
        in0_d  = opnd_data0;
        in1_d  = opnd_data1;
        acc_d  = first_q;
        flag_d = 1'b0;
      end else begin
        flag_d = !first_q;
        if (dim_q) in0_d = opnd_data0;
        else       in1_d = opnd_data0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latched instruction fields and element countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      red_q     <= 1'b0;
      dim_q     <= 1'b0;
      first_q   <= 1'b0;
      ident_q   <= '0;
      rem_q     <= '0;
      cu_opcode <= '0;
      cu_fn     <= '0;
    end else if (instr_hs) begin
      red_q     <= instr_reduction_flag;
      dim_q     <= instr_reduction_dim;
      first_q   <= 1'b1;
      ident_q   <= instr_identity;
      rem_q     <= instr_num_elems;
      cu_opcode <= instr_opcode;
      cu_fn     <= instr_fn;
    end else if (opnd_hs) begin
      rem_q     <= rem_q - ELEM_BITS'(1);
      first_q   <= 1'b0;
    end
  end

  // In-flight valid/tag shift register; the last stage lines up with cu_data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[CU_LATENCY-1:0], push_tag};
      tag_pipe_q <= {tag_pipe_q[CU_LATENCY-1:0], new_tag};
    end
  end

  // Registered lane controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      cu_data_in0       <= '0;
      cu_data_in1       <= '0;
      cu_acc_reset      <= 1'b0;
      cu_reduction_flag <= 1'b0;
      cu_reduction_dim  <= 1'b0;
    end else begin
      cu_data_in0       <= in0_d;
      cu_data_in1       <= in1_d;
      cu_acc_reset      <= acc_d;
      cu_reduction_flag <= flag_d;
      cu_reduction_dim  <= dim_q;
    end
  end

  simd_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pop_vld),
    .wdata_i ({tag_pipe_q[CU_LATENCY].last, cu_data_out}),
    .pop_i   (res_ready),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign res_last  = fifo_rdata[DATA_WIDTH];

endmodule
